// File: rtl/aes_pkg.sv
// Shared definitions for the AES/UART framing sequencer.
package aes_pkg;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    ST_COLLECT  = 2'd0,
    ST_LAUNCH   = 2'd1,
    ST_WAIT_AES = 2'd2,
    ST_SEND     = 2'd3
  } aes_seq_state_t;

  localparam int AES_BLOCK_BITS  = 128;
  localparam int AES_BLOCK_BYTES = 16;

  localparam int DEFAULT_IDLE_TIMEOUT = 1_000_000;
  localparam int DEFAULT_AES_TIMEOUT  = 1024;

endpackage : aes_pkg

// File: rtl/aes_uart_sequencer.sv
// Collects 16 UART bytes into an AES block, launches the core, waits for the
// ciphertext and streams it back out to the UART transmitter byte by byte.
module aes_uart_sequencer
  import aes_pkg::*;
#(
  parameter int IDLE_TIMEOUT = DEFAULT_IDLE_TIMEOUT,
  parameter int AES_TIMEOUT  = DEFAULT_AES_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                rx_byte,
  input  logic                      rx_valid,
  output logic [0:AES_BLOCK_BITS-1] aes_data,
  output logic                      aes_start,
  input  logic [0:AES_BLOCK_BITS-1] aes_result,
  input  logic                      aes_done,
  output logic [7:0]                tx_byte,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      busy,
  output logic                      overrun,
  output logic                      aes_timeout
);

  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam int WAIT_W = $clog2(AES_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(AES_TIMEOUT - 1);
  localparam logic [3:0]        LAST_BYTE = 4'(AES_BLOCK_BYTES - 1);

  aes_seq_state_t              state_q, state_d;
  logic [3:0]                  rx_idx_q, rx_idx_d;
  logic [3:0]                  tx_idx_q, tx_idx_d;
  logic [IDLE_W-1:0]           idle_cnt_q, idle_cnt_d;
  logic [WAIT_W-1:0]           wait_cnt_q, wait_cnt_d;
  logic [0:AES_BLOCK_BITS-1]   data_q, data_d;
  logic [0:AES_BLOCK_BITS-1]   tx_sr_q, tx_sr_d;
  logic                        start_q, start_d;
  logic                        tx_valid_q, tx_valid_d;
  logic                        busy_q, busy_d;
  logic                        overrun_q, overrun_d;
  logic                        aes_to_q, aes_to_d;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d    = state_q;
    rx_idx_d   = rx_idx_q;
    tx_idx_d   = tx_idx_q;
    idle_cnt_d = idle_cnt_q;
    wait_cnt_d = wait_cnt_q;
    data_d     = data_q;
    tx_sr_d    = tx_sr_q;
    overrun_d  = overrun_q;
    aes_to_d   = aes_to_q;

    case (state_q)
      ST_COLLECT: begin
        if (rx_valid) begin
          // A byte always beats a coincident idle timeout.
          data_d[{rx_idx_q, 3'b000} +: 8] = rx_byte;
          rx_idx_d   = rx_idx_q + 4'd1;
          idle_cnt_d = IDLE_W'(0);
          if (rx_idx_q == LAST_BYTE) begin
            state_d = ST_LAUNCH;
          end else begin
            state_d = ST_COLLECT;
          end
        end else if (rx_idx_q != 4'd0) begin
          if (idle_cnt_q == IDLE_LAST) begin
            // Abandon the partial frame; its bytes are simply overwritten later.
            rx_idx_d   = 4'd0;
            idle_cnt_d = IDLE_W'(0);
          end else begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
          end
        end else begin
          idle_cnt_d = IDLE_W'(0);
        end
      end
      ST_LAUNCH: begin
        state_d    = ST_WAIT_AES;
        wait_cnt_d = WAIT_W'(0);
      end
      ST_WAIT_AES: begin
        // wait_cnt_q == 0 marks the first cycle, where a stale done is ignored.
        if (aes_done && (wait_cnt_q != WAIT_W'(0))) begin
          tx_sr_d  = aes_result;
          tx_idx_d = 4'd0;
          state_d  = ST_SEND;
        end else if (wait_cnt_q == WAIT_LAST) begin
          aes_to_d = 1'b1;
          rx_idx_d = 4'd0;
          state_d  = ST_COLLECT;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_SEND: begin
        if (tx_valid_q && tx_ready) begin
          tx_sr_d  = {tx_sr_q[8:AES_BLOCK_BITS-1], 8'h00};
          tx_idx_d = tx_idx_q + 4'd1;
          if (tx_idx_q == LAST_BYTE) begin
            state_d  = ST_COLLECT;
            rx_idx_d = 4'd0;
          end else begin
            state_d = ST_SEND;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d  = ST_COLLECT;
        rx_idx_d = 4'd0;
      end
    endcase

    // The frame-completing byte is consumed in COLLECT, so it never lands here.
    if (rx_valid && (state_q != ST_COLLECT)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_d;
    end

    // Status outputs are decoded from the next state so they come straight off flops.
    start_d    = (state_d == ST_LAUNCH);
    tx_valid_d = (state_d == ST_SEND);
    busy_d     = (state_d != ST_COLLECT);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_COLLECT;
      rx_idx_q   <= 4'd0;
      tx_idx_q   <= 4'd0;
      idle_cnt_q <= IDLE_W'(0);
      wait_cnt_q <= WAIT_W'(0);
      data_q     <= {AES_BLOCK_BITS{1'b0}};
      tx_sr_q    <= {AES_BLOCK_BITS{1'b0}};
      start_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      aes_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_idx_q   <= rx_idx_d;
      tx_idx_q   <= tx_idx_d;
      idle_cnt_q <= idle_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      data_q     <= data_d;
      tx_sr_q    <= tx_sr_d;
      start_q    <= start_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      aes_to_q   <= aes_to_d;
    end
  end

  assign aes_data    = data_q;
  assign aes_start   = start_q;
  assign tx_byte     = tx_sr_q[0:7];
  assign tx_valid    = tx_valid_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign aes_timeout = aes_to_q;

endmodule : aes_uart_sequencer

// File: tb/tb_aes_uart_sequencer.sv
// Directed self-checking bench for aes_uart_sequencer with a behavioural core stand-in.
module tb_aes_uart_sequencer;
  import aes_pkg::*;

  localparam int IDLE_TO  = 50;
  localparam int AES_TO   = 20;
  localparam int CORE_LAT = 4;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   rx_byte = 8'h00;
  logic         rx_valid = 1'b0;
  logic [0:127] aes_data;
  logic         aes_start;
  logic [0:127] aes_result = 128'h0;
  logic         aes_done = 1'b0;
  logic [7:0]   tx_byte;
  logic         tx_valid;
  logic         tx_ready = 1'b0;
  logic         busy;
  logic         overrun;
  logic         aes_timeout;

  int n_checks = 0;
  int n_errors = 0;
  int start_cnt = 0;
  int core_cnt = 0;
  bit core_en = 1'b1;

  aes_uart_sequencer #(.IDLE_TIMEOUT(IDLE_TO), .AES_TIMEOUT(AES_TO)) dut (
    .clk(clk), .reset(reset),
    .rx_byte(rx_byte), .rx_valid(rx_valid),
    .aes_data(aes_data), .aes_start(aes_start),
    .aes_result(aes_result), .aes_done(aes_done),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .overrun(overrun), .aes_timeout(aes_timeout)
  );

  always #5 clk = ~clk;

  // Core stand-in: done stays high (stale) one cycle after a launch, then
  // rises again CORE_LAT cycles later with the known FIPS-197 ciphertext.
  always @(posedge clk) begin
    if (aes_start) begin
      core_cnt <= CORE_LAT;
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == CORE_LAT) aes_done <= 1'b0;
      if (core_cnt == 1 && core_en) begin
        aes_done   <= 1'b1;
        aes_result <= (aes_data === PT) ? CT : ~aes_data;
      end
    end
  end

  // Launch pulse counter.
  always @(posedge clk) begin
    if (aes_start) start_cnt <= start_cnt + 1;
  end

  function automatic logic [7:0] byte_of(input logic [127:0] v, input int n);
    logic [127:0] s;
    s = v << (8 * n);
    return s[127:120];
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [127:0] blk);
    int base;
    base = start_cnt;
    for (int i = 0; i < 16; i++) begin
      rx_byte  = byte_of(blk, i);
      rx_valid = 1'b1;
      if (i == 15) chk("no_early_start", start_cnt, base);
      tick();
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (!(aes_done && core_cnt == 0) && c < 100) begin
      tick();
      c++;
    end
    chk("done_wait_bound", (c < 100), 1);
  endtask

  // Receives the 16 ciphertext bytes; every cycle with tx_valid is checked
  // against the expected byte, which also covers stability under stalls.
  task automatic recv_frame(input bit random_ready, input string tag);
    int n;
    int cyc;
    n = 0;
    cyc = 0;
    while (n < 16 && cyc < 400) begin
      tx_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tx_valid) chk(tag, tx_byte, byte_of(CT, n));
      else chk({tag, "_valid"}, tx_valid, 1);
      if (tx_valid && tx_ready) n++;
      tick();
      cyc++;
    end
    tx_ready = 1'b0;
    chk({tag, "_count"}, n, 16);
    if (!random_ready) chk({tag, "_cycles"}, cyc, 16);
    chk({tag, "_valid_drop"}, tx_valid, 0);
    chk({tag, "_busy_drop"}, busy, 0);
  endtask

  task automatic launch_and_wait(input string tag);
    send_frame(PT);
    chk({tag, "_start"}, aes_start, 1);
    chk({tag, "_busy"}, busy, 1);
    tick();
    chk({tag, "_start_once"}, aes_start, 0);
    chk({tag, "_data"}, aes_data, PT);
    wait_done();
    chk({tag, "_no_early_tx"}, tx_valid, 0);
    tick();
    chk({tag, "_tx_latency"}, tx_valid, 1);
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    tick();
    tick();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", aes_start, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout", aes_timeout, 0);
    chk("rst_data", aes_data, 0);
    chk("rst_tx_byte", tx_byte, 0);
    reset = 1'b0;
    tick();

    // FIPS-197 vector, full-rate transmit
    launch_and_wait("fips");
    recv_frame(1'b0, "fips_tx");
    chk("fips_start_count", start_cnt, 1);

    // Transmit backpressure
    launch_and_wait("bp");
    recv_frame(1'b1, "bp_tx");

    // Idle timeout discards a partial frame
    for (int i = 0; i < 5; i++) begin
      rx_byte  = 8'hA0 + 8'(i);
      rx_valid = 1'b1;
      tick();
    end
    rx_valid = 1'b0;
    repeat (60) tick();
    chk("idle_busy", busy, 0);
    chk("idle_no_start", start_cnt, 2);
    launch_and_wait("idle");
    recv_frame(1'b0, "idle_tx");

    // Overrun during WAIT_AES and SEND
    chk("ovr_pre", overrun, 0);
    send_frame(PT);
    chk("ovr_start", aes_start, 1);
    tick();
    rx_byte  = 8'h77;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    chk("ovr_wait", overrun, 1);
    wait_done();
    tick();
    chk("ovr_tx_valid", tx_valid, 1);
    tx_ready = 1'b0;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    chk("ovr_send", overrun, 1);
    recv_frame(1'b0, "ovr_tx");
    launch_and_wait("ovr_next");
    recv_frame(1'b0, "ovr_next_tx");
    chk("ovr_sticky", overrun, 1);

    // AES timeout with a core that never finishes
    core_en = 1'b0;
    send_frame(PT);
    chk("to_start", aes_start, 1);
    tick();
    repeat (19) tick();
    chk("to_not_yet", aes_timeout, 0);
    chk("to_busy", busy, 1);
    chk("to_no_tx_a", tx_valid, 0);
    tick();
    chk("to_flag", aes_timeout, 1);
    chk("to_collect", busy, 0);
    chk("to_no_tx_b", tx_valid, 0);
    core_en = 1'b1;
    repeat (5) tick();

    // Reset in the middle of transmission
    launch_and_wait("rst");
    tx_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      chk("rst_partial_tx", tx_byte, byte_of(CT, k));
      tick();
    end
    tx_ready = 1'b0;
    reset = 1'b1;
    tick();
    chk("rst_mid_tx_valid", tx_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_overrun", overrun, 0);
    chk("rst_mid_timeout", aes_timeout, 0);
    chk("rst_mid_data", aes_data, 0);
    reset = 1'b0;
    tick();
    launch_and_wait("post_rst");
    recv_frame(1'b0, "post_rst_tx");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_aes_uart_sequencer

// File: doc/aes_uart_sequencer.md
# aes_uart_sequencer

Frames the UART byte stream into 128-bit AES blocks and sequences the encryption core. It collects 16 received bytes, launches one encryption, captures the ciphertext and streams it back out byte-by-byte to the UART transmitter. It sits between the UART RX/TX modules and `encryption_main`, driving that core's `data`/`rx_state` inputs and consuming `encrypted_data`/`encrypted_data_state`.

## Interface
Parameters:
- `IDLE_TIMEOUT`, 1_000_000: clock cycles without a new RX byte before a partial frame is discarded.
- `AES_TIMEOUT`, 1024: maximum cycles waited for `aes_done` before aborting.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx_byte`  in  8  received byte; valid only when `rx_valid` is high.
- `rx_valid`  in  1  one-cycle strobe per received byte.
- `aes_data`  out  128 [0:127]  plaintext block to the core; first RX byte in `[0:7]`.
- `aes_start`  out  1  one-cycle launch pulse; drives the core's `rx_state`.
- `aes_result`  in  128 [0:127]  ciphertext from the core.
- `aes_done`  in  1  core-valid flag (`encrypted_data_state`).
- `tx_byte`  out  8  byte to the transmitter.
- `tx_valid`  out  1  `tx_byte` valid; held until accepted.
- `tx_ready`  in  1  transmitter can accept; transfer occurs when `tx_valid && tx_ready`.
- `busy`  out  1  high in any state other than COLLECT.
- `overrun`  out  1  sticky: an RX byte arrived while not in COLLECT.
- `aes_timeout`  out  1  sticky: the AES wait expired.

## Operation
- States: COLLECT, LAUNCH, WAIT_AES, SEND.
- **COLLECT:** each `rx_valid` writes `rx_byte` into `aes_data[8*i +: 8]` (big-endian, i = 0..15) and increments the 4-bit index `i`.
  - The idle counter clears on every byte and increments otherwise, but only while `i != 0`.
  - When the idle counter reaches `IDLE_TIMEOUT`, `i` returns to 0. The partial data stays in the register and no flag is raised.
  - Accepting byte 15 moves the FSM to LAUNCH.
- **LAUNCH:** `aes_start` is high for exactly one cycle, then the FSM goes to WAIT_AES. `aes_data` is stable from LAUNCH until the FSM leaves WAIT_AES.
- **WAIT_AES:**
  - `aes_done` is ignored in the first WAIT_AES cycle, so a stale done from the previous block is not taken.
  - On the first later cycle with `aes_done` high, `aes_result` is latched into a 128-bit TX shift register, the byte index resets, and the FSM goes to SEND.
  - The wait counter counts from 0. If it reaches `AES_TIMEOUT` first, `aes_timeout` is set, `i` clears and the FSM returns to COLLECT without transmitting.
- **SEND:** `tx_byte` = TX register `[0:7]` and `tx_valid` is high.
  - On each handshake, the register shifts left 8 bits and the index increments.
  - The handshake for byte 15 returns the FSM to COLLECT with `i` = 0, and `tx_valid` drops on the next cycle.
- **RX outside COLLECT:** an `rx_valid` in any other state is dropped and sets `overrun`. The byte that completes a frame (byte 15) is not an overrun.
- **Simultaneous events:** if `rx_valid` and the idle timeout occur in the same cycle, the byte wins: it is stored at the current `i` and the counter clears.
- **Reset:** `reset` in any state, including mid-frame or mid-send, forces COLLECT with `i` = 0 and clears all counters and flags. Any in-flight AES result is discarded.

## Timing
- Reset values:
  - All outputs, including `aes_data` and the TX register, are 0.
  - `tx_valid`, `aes_start`, `busy`, `overrun` and `aes_timeout` are 0.
- RX byte 15 accepted at cycle N:
  - FSM is in LAUNCH during N+1, with `aes_start` high and `busy` high.
  - WAIT_AES begins at N+2.
- `aes_done` first seen high at cycle M (M ≥ N+3): `tx_valid` is high with ciphertext byte 0 at M+1.
- TX throughput: one byte per cycle when `tx_ready` is held high.
- Cycle count with a zero-latency core: 16 bytes out over 16 cycles; total frame-to-last-byte is 2 + core latency + 16 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `aes_pkg`:
  - FSM state enum `aes_seq_state_t`.
  - Constants `AES_BLOCK_BITS` = 128 and `AES_BLOCK_BYTES` = 16.
  - Default timeout constants.
- Single module, no sub-modules. The parent instantiates `aes_uart_sequencer` beside the key expansion and encryption core.

## Test plan
- **FIPS-197 vector:** key 000102…0f, 16 RX bytes 00 11 22 … ff → `aes_start` pulses once, exactly one cycle after byte 15. TX emits 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a in order.
- **TX backpressure:** `tx_ready` toggled randomly → 16 bytes out, none duplicated or lost, `tx_byte` stable while stalled.
- **Idle timeout:** `IDLE_TIMEOUT` = 50; send 5 bytes, idle 60 cycles, then send the FIPS plaintext → same ciphertext as the first scenario and no `aes_start` before byte 16 of the new frame.
- **Overrun:** inject an `rx_valid` during WAIT_AES and during SEND → `overrun` = 1 and stays 1. The ciphertext is unaffected and the next frame starts at index 0.
- **AES timeout:** core model never asserts done, `AES_TIMEOUT` = 20 → `aes_timeout` = 1 twenty cycles into WAIT_AES, no `tx_valid`, and the FSM returns to COLLECT.
- **Reset mid-send:** assert `reset` after 7 TX bytes → next cycle `tx_valid` = 0, `busy` = 0 and all flags are 0. A full new frame then encrypts correctly.
